// File: rtl/dm_lsu_pkg.sv
// dm_lsu_pkg: shared types and constants for the data-memory
// load/store initiator.
package dm_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_RD = 3'd1,
    WAIT_RD  = 3'd2,
    ISSUE_WR = 3'd3,
    RESP     = 3'd4
  } state_e;

  localparam int LaneW = 8;
  localparam int OffW  = 2;

endpackage

// File: rtl/dm_lsu_master_if.sv
// dm_lsu_master_if: CPU request/response handshake plus the
// word-only data memory port.
interface dm_lsu_master_if #(
  parameter int ADSize = 16,
  parameter int DASize = 32,
  parameter int AddrW  = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [AddrW-1:0]  req_addr;
  logic [DASize-1:0] req_wdata;

  logic              rsp_valid;
  logic [DASize-1:0] rsp_rdata;
  logic              rsp_err;

  logic              DM_enable;
  logic              DM_write;
  logic [ADSize-1:0] DM_address;
  logic [DASize-1:0] DM_in;
  logic [DASize-1:0] DM_out;

  modport master (
    input  req_valid, req_write, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output DM_enable, DM_write, DM_address, DM_in,
    input  DM_out
  );

  modport slave (
    output req_valid, req_write, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  DM_enable, DM_write, DM_address, DM_in,
    output DM_out
  );

endinterface

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: little-endian lane extract/extend for loads and
// lane merge for read-modify-write stores.
module dm_lane_unit
  import dm_lsu_pkg::*;
(
  input  size_e            size,
  input  logic [OffW-1:0]  off,
  input  logic             uns,
  input  logic [31:0]      rword,
  input  logic [31:0]      wdata,
  output logic [31:0]      ldata,
  output logic [31:0]      mword
);

  logic [4:0]  sh;
  logic [31:0] rs;
  logic [31:0] bmask;

  assign sh = {off, 3'b000};
  assign rs = rword >> sh;

  always_comb begin
    ldata = rword;
    bmask = '1;
    unique case (size)
      SZ_B: begin
        ldata = {{24{rs[7] & ~uns}}, rs[7:0]};
        bmask = 32'h0000_00ff << sh;
      end
      SZ_H: begin
        ldata = {{16{rs[15] & ~uns}}, rs[15:0]};
        bmask = 32'h0000_ffff << sh;
      end
      default: ;
    endcase
    // word stores take the full mask, so wdata passes through
    mword = (rword & ~bmask) | ((wdata << sh) & bmask);
  end

endmodule

// File: rtl/dm_lsu_master.sv
// dm_lsu_master: byte/half/word load-store initiator driving the
// word-only data memory port, using RMW for sub-word stores.
module dm_lsu_master
  import dm_lsu_pkg::*;
#(
  parameter int ADSize = 16,
  parameter int DASize = 32,
  parameter int AddrW  = 32
) (
  input logic             clk,
  input logic             rst,
  dm_lsu_master_if.master bus
);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  size_e               size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADSize-1:0]   widx_q, widx_d;
  logic [OffW-1:0]     off_q, off_d;
  logic [DASize-1:0]   wdata_q, wdata_d;
  logic [DASize-1:0]   din_q, din_d;
  logic [DASize-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  size_e               req_sz;
  logic                mis, oor, bad;
  logic [DASize-1:0]   ld_data, mg_word;

  assign req_sz = size_e'(bus.req_size);
  assign oor = (bus.req_addr >> (ADSize + OffW)) != '0;
  assign mis = (req_sz == SZ_X)
             | ((req_sz == SZ_H) & bus.req_addr[0])
             | ((req_sz == SZ_W) & (|bus.req_addr[1:0]));
  assign bad = mis | oor;

  dm_lane_unit u_lane (
    .size  (size_q),
    .off   (off_q),
    .uns   (uns_q),
    .rword (bus.DM_out),
    .wdata (wdata_q),
    .ldata (ld_data),
    .mword (mg_word)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    widx_d  = widx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = req_sz;
          uns_d   = bus.req_unsigned;
          widx_d  = bus.req_addr[ADSize+1:OffW];
          off_d   = bus.req_addr[OffW-1:0];
          wdata_d = bus.req_wdata;
          din_d   = bus.req_wdata;
          rdata_d = '0;
          err_d   = bad;
          unique case (1'b1)
            bad:
              state_d = RESP;
            !bad && !bus.req_write:
              state_d = ISSUE_RD;
            !bad && bus.req_write && req_sz == SZ_W:
              state_d = ISSUE_WR;
            default:
              state_d = ISSUE_RD;
          endcase
        end
      end
      ISSUE_RD: state_d = WAIT_RD;
      WAIT_RD: begin
        if (write_q) begin
          din_d   = mg_word;
          state_d = ISSUE_WR;
        end else begin
          rdata_d = ld_data;
          state_d = RESP;
        end
      end
      ISSUE_WR: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      widx_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      widx_q  <= widx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = state_q == IDLE;
  assign bus.rsp_valid  = state_q == RESP;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = err_q;
  assign bus.DM_enable  = (state_q == ISSUE_RD)
                        | (state_q == ISSUE_WR);
  assign bus.DM_write   = state_q == ISSUE_WR;
  assign bus.DM_address = widx_q;
  assign bus.DM_in      = din_q;

endmodule

// File: tb/tb_dm_lsu_master.sv
// tb_dm_lsu_master: table-driven and random load/store checks of
// dm_lsu_master against a behavioural memory model.
module tb_dm_lsu_master;
  import dm_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  dm_lsu_master_if #(.ADSize(16), .DASize(32), .AddrW(32)) bus ();

  dm_lsu_master #(.ADSize(16), .DASize(32), .AddrW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [int];
  int wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0, dbl = 0;
  logic [15:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  logic prev_rv = 1'b0;
  int errs = 0, checks = 0;

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 65536; k++) mem[k] <= '0;
    end else if (!rst && bus.DM_enable && bus.DM_write) begin
      mem[bus.DM_address] <= bus.DM_in;
      wr_cnt <= wr_cnt + 1;
      last_wa <= bus.DM_address;
      last_wd <= bus.DM_in;
    end
    if (!rst && bus.DM_enable && !bus.DM_write) begin
      bus.DM_out <= mem[bus.DM_address];
      rd_cnt <= rd_cnt + 1;
    end else begin
      bus.DM_out <= $urandom;
    end
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (prev_rv && bus.rsp_valid) dbl <= dbl + 1;
    prev_rv <= bus.rsp_valid;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory semantics.
  task automatic model(input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd, output logic er,
                       output int nrd, output int nwr);
    int idx, sh, nb;
    logic [31:0] mask, old, v;
    idx = int'(a[17:2]);
    sh = 8 * int'(a[1:0]);
    er = (sz == 2'd3) || (sz == 2'd1 && a[0])
      || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'h0004_0000);
    rd = '0; nrd = 0; nwr = 0; lat = 1;
    if (er) return;
    nb = 1 << sz;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    old = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (!w) begin
      v = (old >> sh) & mask;
      if (!u && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      rd = v; lat = 3; nrd = 1;
    end else begin
      ref_mem[idx] = (old & ~(mask << sh)) | ((wd & mask) << sh);
      nwr = 1;
      nrd = (nb < 4) ? 1 : 0;
      lat = (nb < 4) ? 4 : 2;
    end
  endtask

  task automatic xact(input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a,
                      input logic [31:0] wd, output int lat,
                      output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_size = sz;
    bus.req_unsigned = u;
    bus.req_addr = a;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic run(input string tag, input logic w,
                     input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd,
                     output logic er);
    int r0, w0, mlat, mnr, mnw, idx;
    logic [31:0] mrd, mv;
    logic mer;
    r0 = rd_cnt;
    w0 = wr_cnt;
    xact(w, sz, u, a, wd, lat, rd, er);
    model(w, sz, u, a, wd, mlat, mrd, mer, mnr, mnw);
    idx = int'(a[17:2]);
    mv = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    chk({tag, "_lat"}, lat, mlat);
    chk({tag, "_rdata"}, rd, mrd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, mer});
    chk({tag, "_dm_reads"}, rd_cnt - r0, mnr);
    chk({tag, "_dm_writes"}, wr_cnt - w0, mnw);
    chk({tag, "_mem"}, mem[idx], mv);
    if (mnw != 0) begin
      chk({tag, "_wr_addr"}, {16'd0, last_wa}, idx);
      chk({tag, "_wr_data"}, last_wd, mv);
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int lat, w0, r0, p0, e1l, e1r, e1w, e2l, e2r, e2w;
    logic [31:0] rd, d1, d2, e1, e2, m6;
    logic er, x1, x2;
    logic [8:0] rdy_p, rv_p, rdy_e, rv_e;
    string tag;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 2};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h12, 32'h1234_56AA, 32'h0, 1'b0, 4};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 32'hFFFF_FFAA, 1'b0, 3};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 32'h0000_00AA, 1'b0, 3};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h16, 32'h0000_8001, 32'h0, 1'b0, 4};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 32'hFFFF_8001, 1'b0, 3};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 32'h0000_8001, 1'b0, 3};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h3, 32'h1234, 32'h0, 1'b1, 1};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h4_0000, 32'h0, 32'h0, 1'b1, 1};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h8001_0000, 1'b0, 3};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h11AA_3344, 1'b0, 3};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", {27'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err,
        bus.DM_enable, bus.DM_write}, 32'h10);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_addr", {16'd0, bus.DM_address}, 32'h0);
    chk("rst_din", bus.DM_in, 32'h0);
    clr = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      tag = $sformatf("v%0d", i);
      run(tag, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr,
          tbl[i].wdata, lat, rd, er);
      chk({tag, "_tbl_lat"}, lat, tbl[i].lat);
      chk({tag, "_tbl_rdata"}, rd, tbl[i].rd);
      chk({tag, "_tbl_err"}, {31'd0, er}, {31'd0, tbl[i].err});
    end

    // back-to-back loads with req_valid held high
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e1l, e1, x1, e1r, e1w);
    model(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, e2l, e2, x2, e2r, e2w);
    rdy_p = '0; rv_p = '0; d1 = '0; d2 = '0;
    rdy_e = 9'b1_0001_0001;
    rv_e = 9'b0_1000_1000;
    p0 = dbl;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size = 2'd2;
    bus.req_addr = 32'h10;
    for (int j = 0; j < 9; j++) begin
      if (j > 0) @(negedge clk);
      rdy_p[j] = bus.req_ready;
      rv_p[j] = bus.rsp_valid;
      if (j == 3) d1 = bus.rsp_rdata;
      if (j == 7) d2 = bus.rsp_rdata;
      if (j == 1) bus.req_addr = 32'h14;
      if (j == 5) bus.req_valid = 1'b0;
    end
    chk("b2b_ready", {23'd0, rdy_p}, {23'd0, rdy_e});
    chk("b2b_rsp", {23'd0, rv_p}, {23'd0, rv_e});
    chk("b2b_d1", d1, e1);
    chk("b2b_d2", d2, e2);

    // reset while an RMW byte store sits in WAIT_RD
    m6 = mem[6];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'd0;
    bus.req_addr = 32'h18;
    bus.req_wdata = 32'h55;
    chk("rmw_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_issue_rd", {30'd0, bus.DM_enable, bus.DM_write}, 32'd2);
    @(negedge clk);
    w0 = wr_cnt;
    r0 = rsp_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_ctl", {27'd0, bus.req_ready, bus.rsp_valid,
        bus.rsp_err, bus.DM_enable, bus.DM_write}, 32'h10);
    chk("rmw_rst_addr", {16'd0, bus.DM_address}, 32'h0);
    chk("rmw_rst_din", bus.DM_in, 32'h0);
    chk("rmw_rst_rdata", bus.rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rmw_no_write", wr_cnt - w0, 32'd0);
    chk("rmw_no_rsp", rsp_cnt - r0, 32'd0);
    chk("rmw_mem", mem[6], m6);

    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)
        a = $urandom | 32'h0004_0000;
      else
        a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      run($sformatf("r%0d", t), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, lat, rd, er);
    end

    chk("rsp_back_to_back", dbl - p0, 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
